// File: rtl/pi_digit_sequencer_if.sv
// Signal bundle between the pi digit sequencer, its triplet ROM and the
// 7-segment display path. The sequencer sits on the slave side.
interface pi_digit_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               run;
    logic               step;
    logic [DWELL_W-1:0] dwell;
    logic [8:0]         rom_addr;
    logic [11:0]        dpd_digits;
    logic [3:0]         digit_out;
    logic               digit_valid;
    logic               blank;
    logic               wrapped;

    modport master (
        output run, step, dwell, dpd_digits,
        input  rom_addr, digit_out, digit_valid, blank, wrapped
    );

    modport slave (
        input  run, step, dwell, dpd_digits,
        output rom_addr, digit_out, digit_valid, blank, wrapped
    );
endinterface

// File: rtl/pi_digit_sequencer.sv
// Walks a BCD-triplet ROM of pi and presents one digit at a time to a
// 7-segment decoder, inserting the decimal point after the leading 3.
//
// state | meaning
// IDLE  | after reset, waiting for run or step
// FETCH | latch the ROM triplet for rom_addr, restart at its first digit
// SHOW  | display triplet[sel] for dwell+1 cycles
// DOT   | display the decimal point for dwell+1 cycles
// GAP   | one blank cycle, next-digit advance applied on exit
// PAUSE | blank, advance already applied, waiting for run or step
module pi_digit_sequencer #(
    parameter int LAST_ADDR = 466,
    parameter int DWELL_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    pi_digit_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, SHOW, DOT, GAP, PAUSE} state_t;

    localparam logic [8:0] LAST = 9'(LAST_ADDR);

    state_t             state_q, state_d;
    state_t             resume_q, resume_d;
    state_t             adv_state;
    logic [8:0]         addr_q, addr_d, adv_addr;
    logic [1:0]         sel_q, sel_d, adv_sel;
    logic               dot_q, dot_d, adv_dot, adv_wrap;
    logic [11:0]        trip_q, trip_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [3:0]         digit_q, digit_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;
    logic               go;

    assign go = bus.run | bus.step;

    function automatic logic [3:0] pick(input logic [11:0] t, input logic [1:0] s);
        case (s)
            2'd0:    pick = t[11:8];
            2'd1:    pick = t[7:4];
            default: pick = t[3:0];
        endcase
    endfunction

    // Work out which digit follows the current one (used when leaving GAP).
    always_comb begin
        adv_state = FETCH;
        adv_addr  = addr_q;
        adv_sel   = sel_q;
        adv_dot   = dot_q;
        adv_wrap  = 1'b0;
        if (addr_q == 9'd0 && sel_q == 2'd0 && !dot_q) begin
            adv_state = DOT;
        end else if (sel_q < 2'd2) begin
            adv_state = SHOW;
            adv_sel   = sel_q + 2'd1;
        end else if (addr_q == LAST) begin
            adv_addr = 9'd0;
            adv_wrap = 1'b1;
            adv_dot  = 1'b0;
        end else begin
            adv_addr = addr_q + 9'd1;
        end
    end

    // Next-state and next-output logic; display registers load on SHOW/DOT entry.
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        dot_d    = dot_q;
        trip_d   = trip_q;
        cnt_d    = cnt_q;
        digit_d  = digit_q;
        wrap_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) state_d = FETCH;
            end
            FETCH: begin
                trip_d  = bus.dpd_digits;
                sel_d   = 2'd0;
                state_d = SHOW;
            end
            SHOW, DOT: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    if (state_q == DOT) dot_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                addr_d = adv_addr;
                sel_d  = adv_sel;
                dot_d  = adv_dot;
                wrap_d = adv_wrap;
                if (bus.run) begin
                    state_d = adv_state;
                end else begin
                    state_d  = PAUSE;
                    resume_d = adv_state;
                end
            end
            PAUSE: begin
                if (go) state_d = resume_q;
            end
            default: state_d = IDLE;
        endcase
        if ((state_d == SHOW || state_d == DOT) && state_d != state_q) begin
            cnt_d   = bus.dwell;
            digit_d = (state_d == SHOW) ? pick(trip_d, sel_d) : 4'hA;
        end
        valid_d = (state_d == SHOW) || (state_d == DOT);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            resume_q <= FETCH;
            addr_q   <= 9'd0;
            sel_q    <= 2'd0;
            dot_q    <= 1'b0;
            trip_q   <= 12'd0;
            cnt_q    <= '0;
            digit_q  <= 4'd0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            dot_q    <= dot_d;
            trip_q   <= trip_d;
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.rom_addr    = addr_q;
    assign bus.digit_out   = digit_q;
    assign bus.digit_valid = valid_q;
    assign bus.blank       = ~valid_q;
    assign bus.wrapped     = wrap_q;
endmodule
